// File: rtl/frame_bram_ctrl_if.sv
// Pixel-stream input and frame-BRAM port bundle for frame_bram_ctrl.
// The controller uses the master side; the pixel source and the BRAM side use the slave side.
interface frame_bram_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic              capture;
    logic              show_en;
    logic [23:0]       pixel_in;
    logic [10:0]       hcount;
    logic [9:0]        vcount;
    logic [1:0]        bram_state;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_din;
    logic              in_display_bram;
    logic              frame_done;

    modport master (
        input  capture, show_en, pixel_in, hcount, vcount,
        output bram_state, bram_we, bram_addr, bram_din, in_display_bram, frame_done
    );

    modport slave (
        output capture, show_en, pixel_in, hcount, vcount,
        input  bram_state, bram_we, bram_addr, bram_din, in_display_bram, frame_done
    );
endinterface

// File: rtl/frame_bram_ctrl.sv
// Frame-store controller: captures one IMG_W x IMG_H window of the pixel stream into an
// 8-bit BRAM as RGB332, then replays it by issuing raster-order read addresses.
module frame_bram_ctrl #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17
) (
    input  logic clk,
    input  logic reset,
    frame_bram_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        BRAM_IDLE     = 2'b00,
        CAPTURE_FRAME = 2'b01,
        WRITING_FRAME = 2'b10,
        READING_FRAME = 2'b11
    } state_t;

    localparam logic [10:0] LP_W     = 11'(IMG_W);
    localparam logic [9:0]  LP_H     = 10'(IMG_H);
    localparam logic [10:0] LP_HLAST = 11'(IMG_W - 1);
    localparam logic [9:0]  LP_VLAST = 10'(IMG_H - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_din;
    logic [7:0]        w_rgb332;
    logic              r_we;
    logic              r_done;
    logic              r_rd_d1;
    logic              r_rd_d2;
    logic              w_win;
    logic              w_sof;
    logic              w_last;
    logic              w_wr;
    logic              w_rd;
    logic              w_done;
    logic              w_unused;

    assign w_win    = (bus.hcount < LP_W) && (bus.vcount < LP_H);
    assign w_sof    = (bus.hcount == '0) && (bus.vcount == '0);
    assign w_last   = (bus.hcount == LP_HLAST) && (bus.vcount == LP_VLAST);
    // Raster order keeps the running count equal to vcount*IMG_W+hcount without a multiplier.
    assign w_cur_addr = w_sof ? '0 : r_addr_cnt;
    assign w_rgb332 = {bus.pixel_in[23:21], bus.pixel_in[15:13], bus.pixel_in[7:6]};
    assign w_unused = ^{bus.pixel_in[20:16], bus.pixel_in[12:8], bus.pixel_in[5:0]};

    always_comb begin
        w_next = r_state;
        w_wr   = 1'b0;
        w_rd   = 1'b0;
        w_done = 1'b0;
        case (r_state)
            BRAM_IDLE: begin
                if (bus.capture) w_next = CAPTURE_FRAME;
            end
            CAPTURE_FRAME: begin
                if (w_sof) begin
                    w_wr   = 1'b1;
                    w_next = WRITING_FRAME;
                end
            end
            WRITING_FRAME: begin
                if (w_win) begin
                    w_wr = 1'b1;
                    if (w_last) begin
                        w_done = 1'b1;
                        w_next = bus.show_en ? READING_FRAME : BRAM_IDLE;
                    end
                end
            end
            READING_FRAME: begin
                w_rd = w_win;
                if (bus.capture)       w_next = CAPTURE_FRAME;
                else if (!bus.show_en) w_next = BRAM_IDLE;
            end
            default: w_next = BRAM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= BRAM_IDLE;
            r_addr_cnt <= '0;
            r_addr     <= '0;
            r_din      <= '0;
            r_we       <= 1'b0;
            r_done     <= 1'b0;
            r_rd_d1    <= 1'b0;
            r_rd_d2    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_addr_cnt <= w_win ? w_cur_addr + ADDR_W'(1) : w_cur_addr;
            r_we       <= w_wr;
            r_done     <= w_done;
            if (w_wr || w_rd) r_addr <= w_cur_addr;
            if (w_wr)         r_din  <= w_rgb332;
            // Leaving READING_FRAME flushes both read-flag stages so no stale flag trails out.
            r_rd_d1    <= w_rd && (w_next == READING_FRAME);
            r_rd_d2    <= r_rd_d1 && (w_next == READING_FRAME);
        end
    end

    assign bus.bram_state      = r_state;
    assign bus.bram_we         = r_we;
    assign bus.bram_addr       = r_addr;
    assign bus.bram_din        = r_din;
    assign bus.in_display_bram = r_rd_d2;
    assign bus.frame_done      = r_done;
endmodule

// File: tb/tb_frame_bram_ctrl.sv
// Directed bench for frame_bram_ctrl on a 4x3 window inside an 8x5 raster.
module tb_frame_bram_ctrl;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;
    localparam int HT = 8;
    localparam int VT = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    frame_bram_ctrl_if #(.ADDR_W(AW)) bus();

    frame_bram_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   h = 0;
    int   v = 0;
    int   ph = 0;
    int   pv = 0;
    logic prev_rd;

    function automatic logic [23:0] pix(input int x, input int y);
        if (x == 0 && y == 0) return 24'hFFFFFF;
        if (x == 1 && y == 0) return 24'h80C040;
        if (x == 2 && y == 0) return 24'h1F1F3F;
        return {8'(x * 40 + y * 9 + 3), 8'(y * 50 + x * 7), 8'(x * 13 + y * 90 + 128)};
    endfunction

    // Expected RGB332: fixed vectors are hand-packed, the rest truncate R,G to 3 bits and B to 2.
    function automatic logic [7:0] exp_din(input int x, input int y);
        logic [23:0] p;
        if (x == 0 && y == 0) return 8'hFF;
        if (x == 1 && y == 0) return 8'h99;
        if (x == 2 && y == 0) return 8'h00;
        p = pix(x, y);
        return {p[23:21], p[15:13], p[7:6]};
    endfunction

    function automatic logic inwin(input int x, input int y);
        return (x < W) && (y < H);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s at (%0d,%0d): got %0h expected %0h", tag, ph, pv, obs, exp);
        end
    endtask

    task automatic apply(input logic cap, input logic shw);
        bus.capture  = cap;
        bus.show_en  = shw;
        bus.hcount   = 11'(h);
        bus.vcount   = 10'(v);
        bus.pixel_in = pix(h, v);
        @(posedge clk);
        #1;
        ph = h;
        pv = v;
        h++;
        if (h == HT) begin
            h = 0;
            v++;
            if (v == VT) v = 0;
        end
    endtask

    // Runs the writing frame from sof through the last window pixel; show_en is the opposite
    // of shw_last on every cycle except the last pixel, and capture pulses at cycle cap_at.
    task automatic write_frame(input logic shw_last, input int cap_at);
        int nw;
        nw = 0;
        for (int i = 0; i < 20; i++) begin
            apply(i == cap_at, (i == 19) ? shw_last : ~shw_last);
            check("wr_we", 32'(bus.bram_we), 32'(inwin(ph, pv)));
            if (inwin(ph, pv)) begin
                nw++;
                check("wr_addr", 32'(bus.bram_addr), 32'(pv * W + ph));
                check("wr_din", 32'(bus.bram_din), 32'(exp_din(ph, pv)));
            end
            check("wr_done", 32'(bus.frame_done), 32'(i == 19));
            if (i < 19) check("wr_state", 32'(bus.bram_state), 32'h2);
            else        check("wr_end_state", 32'(bus.bram_state), shw_last ? 32'h3 : 32'h0);
        end
        check("wr_count", 32'(nw), 32'd12);
    endtask

    initial begin
        reset        = 1'b1;
        bus.capture  = 1'b0;
        bus.show_en  = 1'b0;
        bus.hcount   = '0;
        bus.vcount   = '0;
        bus.pixel_in = '0;
        h = 0;
        v = 1;
        apply(0, 0);
        apply(0, 0);
        check("rst_state", 32'(bus.bram_state), 32'h0);
        check("rst_we", 32'(bus.bram_we), 32'h0);
        check("rst_addr", 32'(bus.bram_addr), 32'h0);
        check("rst_din", 32'(bus.bram_din), 32'h0);
        check("rst_disp", 32'(bus.in_display_bram), 32'h0);
        check("rst_done", 32'(bus.frame_done), 32'h0);
        reset = 1'b0;

        apply(0, 0);
        check("idle_state", 32'(bus.bram_state), 32'h0);
        apply(1, 0);
        check("cap_state", 32'(bus.bram_state), 32'h1);
        // Second capture pulse while already waiting must be ignored.
        for (int i = 0; i < 40 && !(h == 0 && v == 0); i++) begin
            apply(i == 2, 0);
            check("wait_state", 32'(bus.bram_state), 32'h1);
            check("wait_we", 32'(bus.bram_we), 32'h0);
        end
        check("at_sof", 32'(h == 0 && v == 0), 32'h1);

        write_frame(1'b1, 3);

        prev_rd = 1'b0;
        for (int i = 0; i < 62; i++) begin
            apply(0, 1);
            check("rd_state", 32'(bus.bram_state), 32'h3);
            check("rd_disp", 32'(bus.in_display_bram), 32'(prev_rd));
            check("rd_we", 32'(bus.bram_we), 32'h0);
            if (inwin(ph, pv)) check("rd_addr", 32'(bus.bram_addr), 32'(pv * W + ph));
            prev_rd = inwin(ph, pv);
        end
        apply(0, 0);
        check("drop_state", 32'(bus.bram_state), 32'h0);
        check("drop_disp0", 32'(bus.in_display_bram), 32'h0);
        apply(0, 0);
        check("drop_disp1", 32'(bus.in_display_bram), 32'h0);
        for (int i = 0; i < 40 && !(h == 0 && v == 0); i++) begin
            apply(0, 0);
            check("idle2_state", 32'(bus.bram_state), 32'h0);
            check("idle2_disp", 32'(bus.in_display_bram), 32'h0);
        end

        // Capture on a sof cycle starts at the following frame's origin.
        apply(1, 0);
        check("sofcap_state", 32'(bus.bram_state), 32'h1);
        check("sofcap_we", 32'(bus.bram_we), 32'h0);
        for (int i = 0; i < 40 && !(h == 0 && v == 0); i++) begin
            apply(0, 0);
            check("wait2_state", 32'(bus.bram_state), 32'h1);
            check("wait2_we", 32'(bus.bram_we), 32'h0);
        end
        write_frame(1'b1, 5);

        for (int i = 0; i < 4; i++) begin
            apply(0, 1);
            check("rd2_state", 32'(bus.bram_state), 32'h3);
        end
        apply(1, 0);
        check("cap_prio_state", 32'(bus.bram_state), 32'h1);
        for (int i = 0; i < 40 && !(h == 0 && v == 0); i++) begin
            apply(0, 0);
            check("wait3_state", 32'(bus.bram_state), 32'h1);
        end

        for (int i = 0; i < 10; i++) begin
            apply(0, 0);
            check("mw_we", 32'(bus.bram_we), 32'(inwin(ph, pv)));
            if (inwin(ph, pv)) check("mw_addr", 32'(bus.bram_addr), 32'(pv * W + ph));
        end
        check("mw_last_addr", 32'(bus.bram_addr), 32'd5);
        reset = 1'b1;
        apply(0, 0);
        reset = 1'b0;
        check("mwrst_state", 32'(bus.bram_state), 32'h0);
        check("mwrst_we", 32'(bus.bram_we), 32'h0);
        check("mwrst_addr", 32'(bus.bram_addr), 32'h0);
        check("mwrst_din", 32'(bus.bram_din), 32'h0);
        check("mwrst_disp", 32'(bus.in_display_bram), 32'h0);
        check("mwrst_done", 32'(bus.frame_done), 32'h0);
        for (int i = 0; i < 40; i++) begin
            apply(0, 0);
            check("post_state", 32'(bus.bram_state), 32'h0);
            check("post_we", 32'(bus.bram_we), 32'h0);
            check("post_done", 32'(bus.frame_done), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
